// File: rtl/rvsteel_spi_peripheral_if.sv
// ---------------------------------------------------------------------------
// rvsteel_spi_peripheral_if
//
// Bundles every non-clock/reset signal of the SPI peripheral:
//   cpol, cpha        mode select (controller side drives, peripheral reads)
//   sclk, pico, cs    SPI pins from the controller (asynchronous to clock)
//   poci, poci_oe     SPI data back to the controller and its output enable
//   tx_data/valid/ready  one-byte transmit holding buffer
//   rx_data/valid/ready  received byte
//   overrun           one-cycle pulse when a byte is overwritten unread
//   dbg_active        FSM state (1 = ACTIVE, 0 = IDLE)
//   dbg_bit_cnt       number of bits sampled in the current byte
//
// Handshake rule for both tx and rx: a transfer happens on a rising clock
// edge where valid and ready are both 1. valid, once raised, holds its data
// until that edge; ready may rise or fall at any time.
//
// Modports: slave is the peripheral, master is whatever drives it.
// ---------------------------------------------------------------------------
interface rvsteel_spi_peripheral_if;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       pico;
    logic       cs;
    logic       poci;
    logic       poci_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       dbg_active;
    logic [2:0] dbg_bit_cnt;

    modport slave (
        input  cpol, cpha, sclk, pico, cs, tx_data, tx_valid, rx_ready,
        output poci, poci_oe, tx_ready, rx_data, rx_valid, overrun,
               dbg_active, dbg_bit_cnt
    );

    modport master (
        output cpol, cpha, sclk, pico, cs, tx_data, tx_valid, rx_ready,
        input  poci, poci_oe, tx_ready, rx_data, rx_valid, overrun,
               dbg_active, dbg_bit_cnt
    );
endinterface

// File: rtl/rvsteel_spi_peripheral.sv
// ---------------------------------------------------------------------------
// rvsteel_spi_peripheral
//
// SPI target running entirely on the system clock. sclk, cs and pico are
// oversampled through SYNC_STAGES synchronizer flops; one more flop on the
// synced sclk gives edge detection. All four CPOL/CPHA modes, MSB first,
// 8-bit frames.
//
// Ports:
//   clock   system clock (sclk must be at most clock/8)
//   reset   asynchronous active-low reset
//   bus     rvsteel_spi_peripheral_if.slave (SPI pins, tx/rx handshakes,
//           overrun pulse, FSM debug state)
// ---------------------------------------------------------------------------
module rvsteel_spi_peripheral #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    rvsteel_spi_peripheral_if.slave      bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Synchronizers
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] pico_sync_q, pico_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    // Control
    state_t     state_q,   state_d;
    logic       cpol_q,    cpol_d;
    logic       cpha_q,    cpha_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    // Receive path (only 7 bits need storing; the 8th comes straight from pico)
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q,  overrun_d;

    // Transmit path
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q,   tx_buf_d;
    logic       tx_full_q,  tx_full_d;

    // Combinational helpers
    logic sclk_s, cs_s, pico_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic load, tx_write;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs};
        pico_sync_d = {pico_sync_q[SYNC_STAGES-2:0], bus.pico};

        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        cs_s   = cs_sync_q[SYNC_STAGES-1];
        pico_s = pico_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;

        // Leading edge leaves the idle level, trailing edge returns to it.
        lead_edge   = (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
        trail_edge  = (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
        sample_edge = cpha_q ? trail_edge : lead_edge;
        shift_edge  = cpha_q ? lead_edge  : trail_edge;

        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        load       = 1'b0;
        tx_write   = bus.tx_valid && !tx_full_q;

        // Consumer handshake; a byte completing this same cycle re-sets rx_valid below.
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    state_d   = ACTIVE;
                    cpol_d    = bus.cpol;
                    cpha_d    = bus.cpha;
                    bit_cnt_d = 3'd0;
                    // With cpha=0 the first bit must be on poci before the first edge.
                    load      = !bus.cpha;
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    // Abandon whatever byte is in flight; the holding buffer survives.
                    state_d    = IDLE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 7'd0;
                    tx_shift_d = 8'd0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[5:0], pico_s};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {rx_shift_q, pico_s};
                            rx_valid_d = 1'b1;
                            overrun_d  = rx_valid_q && !bus.rx_ready;
                        end
                    end
                    // A shift edge seen with bit_cnt at 0 is the byte boundary:
                    // for cpha=0 it follows the 8th sample, for cpha=1 it is the
                    // first edge of a byte. Either way the next byte is loaded.
                    if (shift_edge) begin
                        if (bit_cnt_q == 3'd0) begin
                            load = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            tx_shift_d = tx_full_q ? tx_buf_q : 8'h00;
            tx_full_d  = 1'b0;
        end
        // A write in the same cycle as a load lands after it and stays buffered.
        if (tx_write) begin
            tx_buf_d  = bus.tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            pico_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_shift_q  <= 8'h00;
            tx_buf_q    <= 8'h00;
            tx_full_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            pico_sync_q <= pico_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
        end
    end

    assign bus.poci        = tx_shift_q[7];
    assign bus.poci_oe     = (state_q == ACTIVE);
    assign bus.tx_ready    = !tx_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.dbg_active  = (state_q == ACTIVE);
    assign bus.dbg_bit_cnt = bit_cnt_q;

endmodule
